// File: rtl/sram_axi_bridge_if.sv
// Bundle of the core-facing sram-like ports and the AXI master channels of sram_axi_bridge.
// The master modport is the bridge's view; slave is the core/AXI-fabric side.
interface sram_axi_bridge_if;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = 4;
   localparam int unsigned IDW = 4;

   logic           inst_sram_req;
   logic           inst_sram_wr;
   logic [1:0]     inst_sram_size;
   logic [AW-1:0]  inst_sram_addr;
   logic [SW-1:0]  inst_sram_wstrb;
   logic [DW-1:0]  inst_sram_wdata;
   logic           inst_sram_addr_ok;
   logic           inst_sram_data_ok;
   logic [DW-1:0]  inst_sram_rdata;

   logic           data_sram_req;
   logic           data_sram_wr;
   logic [1:0]     data_sram_size;
   logic [SW-1:0]  data_sram_wstrb;
   logic [AW-1:0]  data_sram_addr;
   logic [DW-1:0]  data_sram_wdata;
   logic           data_sram_addr_ok;
   logic           data_sram_data_ok;
   logic [DW-1:0]  data_sram_rdata;

   logic [IDW-1:0] arid;
   logic [AW-1:0]  araddr;
   logic [7:0]     arlen;
   logic [2:0]     arsize;
   logic [1:0]     arburst;
   logic [1:0]     arlock;
   logic [3:0]     arcache;
   logic [2:0]     arprot;
   logic           arvalid;
   logic           arready;

   logic [IDW-1:0] rid;
   logic [DW-1:0]  rdata;
   logic [1:0]     rresp;
   logic           rlast;
   logic           rvalid;
   logic           rready;

   logic [IDW-1:0] awid;
   logic [AW-1:0]  awaddr;
   logic [7:0]     awlen;
   logic [2:0]     awsize;
   logic [1:0]     awburst;
   logic [1:0]     awlock;
   logic [3:0]     awcache;
   logic [2:0]     awprot;
   logic           awvalid;
   logic           awready;

   logic [IDW-1:0] wid;
   logic [DW-1:0]  wdata;
   logic [SW-1:0]  wstrb;
   logic           wlast;
   logic           wvalid;
   logic           wready;

   logic [IDW-1:0] bid;
   logic [1:0]     bresp;
   logic           bvalid;
   logic           bready;

   modport master (
      input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wstrb, inst_sram_wdata,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wstrb, inst_sram_wdata,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/sram_axi_bridge.sv
// Merges the core's inst (read-only) and data sram-like ports into one AXI master,
// one outstanding transaction per port, single-beat bursts only.
module sram_axi_bridge #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic              clk,
   input  logic              resetn,
   sram_axi_bridge_if.master bus
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   typedef enum logic [0:0] {AR_IDLE, AR_SEND} ar_state_t;

   ar_state_t ar_state, ar_state_nx;

   logic          inst_busy, inst_pend;
   logic [AW-1:0] inst_addr_q;
   logic [1:0]    inst_size_q;

   logic          drd_busy, drd_pend;
   logic [AW-1:0] drd_addr_q;
   logic [1:0]    drd_size_q;

   logic          wr_busy, awvalid_q, wvalid_q;
   logic [AW-1:0] wr_addr_q;
   logic [1:0]    wr_size_q;
   logic [SW-1:0] wr_strb_q;
   logic [DW-1:0] wr_data_q;

   logic          ar_sel_q, ar_sel_nx;   // 1: data slot owns the AR channel
   logic [AW-1:0] araddr_q, araddr_nx;
   logic [2:0]    arsize_q, arsize_nx;
   logic [3:0]    arid_q, arid_nx;

   logic inst_accept, data_free, data_accept, drd_accept, dwr_accept;
   logic inst_r_hit, data_r_hit, b_hit, ar_hs;
   logic unused_sig;

   assign inst_accept = bus.inst_sram_req & ~inst_busy;
   assign data_free   = ~drd_busy & ~wr_busy;
   assign data_accept = bus.data_sram_req & data_free;
   assign drd_accept  = data_accept & ~bus.data_sram_wr;
   assign dwr_accept  = data_accept & bus.data_sram_wr;

   assign inst_r_hit  = bus.rvalid & (bus.rid == INST_ID) & inst_busy;
   assign data_r_hit  = bus.rvalid & (bus.rid == DATA_ID) & drd_busy;
   assign b_hit       = bus.bvalid & (bus.bid == DATA_ID) & wr_busy & ~awvalid_q & ~wvalid_q;
   assign ar_hs       = (ar_state == AR_SEND) & bus.arready;

   assign bus.inst_sram_addr_ok = ~inst_busy;
   assign bus.inst_sram_data_ok = inst_r_hit;
   assign bus.inst_sram_rdata   = bus.rdata;
   assign bus.data_sram_addr_ok = data_free;
   assign bus.data_sram_data_ok = data_r_hit | b_hit;
   assign bus.data_sram_rdata   = bus.rdata;

   assign bus.arid    = arid_q;
   assign bus.araddr  = araddr_q;
   assign bus.arsize  = arsize_q;
   assign bus.arvalid = (ar_state == AR_SEND);
   assign bus.arlen   = 8'd0;
   assign bus.arburst = 2'b01;
   assign bus.arlock  = 2'd0;
   assign bus.arcache = 4'd0;
   assign bus.arprot  = 3'd0;
   assign bus.rready  = 1'b1;

   assign bus.awid    = DATA_ID;
   assign bus.awaddr  = wr_addr_q;
   assign bus.awsize  = {1'b0, wr_size_q};
   assign bus.awvalid = awvalid_q;
   assign bus.awlen   = 8'd0;
   assign bus.awburst = 2'b01;
   assign bus.awlock  = 2'd0;
   assign bus.awcache = 4'd0;
   assign bus.awprot  = 3'd0;

   assign bus.wid     = DATA_ID;
   assign bus.wdata   = wr_data_q;
   assign bus.wstrb   = wr_strb_q;
   assign bus.wlast   = 1'b1;
   assign bus.wvalid  = wvalid_q;
   assign bus.bready  = 1'b1;

   assign unused_sig = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                         bus.rresp, bus.rlast, bus.bresp};

   // AR arbitration: a request accepted this cycle may be picked directly, data wins ties
   always_comb begin
      ar_state_nx = ar_state;
      ar_sel_nx   = ar_sel_q;
      araddr_nx   = araddr_q;
      arsize_nx   = arsize_q;
      arid_nx     = arid_q;
      case (ar_state)
         AR_IDLE: begin
            if (drd_pend | drd_accept) begin
               ar_state_nx = AR_SEND;
               ar_sel_nx   = 1'b1;
               arid_nx     = DATA_ID;
               araddr_nx   = drd_pend ? drd_addr_q : bus.data_sram_addr;
               arsize_nx   = {1'b0, (drd_pend ? drd_size_q : bus.data_sram_size)};
            end else if (inst_pend | inst_accept) begin
               ar_state_nx = AR_SEND;
               ar_sel_nx   = 1'b0;
               arid_nx     = INST_ID;
               araddr_nx   = inst_pend ? inst_addr_q : bus.inst_sram_addr;
               arsize_nx   = {1'b0, (inst_pend ? inst_size_q : bus.inst_sram_size)};
            end
         end
         AR_SEND: begin
            if (bus.arready) ar_state_nx = AR_IDLE;
         end
         default: ar_state_nx = AR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ar_state <= AR_IDLE;
         ar_sel_q <= 1'b0;
         araddr_q <= '0;
         arsize_q <= '0;
         arid_q   <= '0;
      end else begin
         ar_state <= ar_state_nx;
         ar_sel_q <= ar_sel_nx;
         araddr_q <= araddr_nx;
         arsize_q <= arsize_nx;
         arid_q   <= arid_nx;
      end
   end

   // Read slots: busy spans accept..R beat, pending spans accept..AR handshake
   always_ff @(posedge clk) begin
      if (!resetn) begin
         inst_busy   <= 1'b0;
         inst_pend   <= 1'b0;
         inst_addr_q <= '0;
         inst_size_q <= '0;
         drd_busy    <= 1'b0;
         drd_pend    <= 1'b0;
         drd_addr_q  <= '0;
         drd_size_q  <= '0;
      end else begin
         if (inst_accept) begin
            inst_busy   <= 1'b1;
            inst_pend   <= 1'b1;
            inst_addr_q <= bus.inst_sram_addr;
            inst_size_q <= bus.inst_sram_size;
         end else if (inst_r_hit) begin
            inst_busy <= 1'b0;
         end
         if (ar_hs && !ar_sel_q) inst_pend <= 1'b0;

         if (drd_accept) begin
            drd_busy   <= 1'b1;
            drd_pend   <= 1'b1;
            drd_addr_q <= bus.data_sram_addr;
            drd_size_q <= bus.data_sram_size;
         end else if (data_r_hit) begin
            drd_busy <= 1'b0;
         end
         if (ar_hs && ar_sel_q) drd_pend <= 1'b0;
      end
   end

   // Write slot: AW and W launch together and retire independently, then wait for B
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_busy   <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_size_q <= '0;
         wr_strb_q <= '0;
         wr_data_q <= '0;
      end else if (dwr_accept) begin
         wr_busy   <= 1'b1;
         awvalid_q <= 1'b1;
         wvalid_q  <= 1'b1;
         wr_addr_q <= bus.data_sram_addr;
         wr_size_q <= bus.data_sram_size;
         wr_strb_q <= bus.data_sram_wstrb;
         wr_data_q <= bus.data_sram_wdata;
      end else begin
         if (b_hit)                     wr_busy   <= 1'b0;
         if (awvalid_q && bus.awready)  awvalid_q <= 1'b0;
         if (wvalid_q && bus.wready)    wvalid_q  <= 1'b0;
      end
   end
endmodule
